// File: rtl/spi_reg_bank.sv
// spi_reg_bank: mode-0 SPI target exposing NUM_REGS configuration registers.
// Every SPI pin is synchronised into clk, and all of the logic runs on clk.
// A write reaches the registers only when its frame is exactly FRAME bits long.
// Read frames return the addressed register on cipo, MSB first.
//
//   state   | meaning
//   IDLE    | waiting for an ncs fall
//   ADDR    | shifting in the R/W bit and the address
//   DATA    | shifting in write data, or shifting out read data
//   COMMIT  | one cycle that applies or rejects the finished frame
module spi_reg_bank #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 2);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME + 1);
    localparam logic [CNT_W-1:0] CNT_ALAST = CNT_W'(ADDR_W);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADDR   = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
    logic                   sclk_s, ncs_s, copi_s;
    logic                   sclk_prev, ncs_prev;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic [SYNC_STAGES-1:0] flush_sr;
    logic                   armed;

    logic [1:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME-1:0]       rx_sh;
    logic [FRAME-1:0]       rx_next;
    logic [ADDR_W-1:0]      addr_now;
    logic                   rw_now;
    logic                   rd_active;
    logic [DATA_W-1:0]      tx_sh;
    logic                   cipo_q;
    logic [DATA_W-1:0]      snap;

    logic                   c_rw;
    logic [ADDR_W-1:0]      c_addr;
    logic [DATA_W-1:0]      c_data;
    logic [NUM_REGS-1:0]    c_hit;

    logic [DATA_W-1:0]      reg_q [NUM_REGS];

    // Synchroniser chains. ncs resets high so that reset looks like "not selected".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            copi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];

    // Previous value of each synchronised strobe, used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
        end
    end

    // After reset the ncs chain still holds its reset ones, so a pin that is
    // already low would look like a fresh fall. A frame may only start once a
    // real high level has made it through the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_sr <= '0;
            armed    <= 1'b0;
        end else begin
            flush_sr <= {flush_sr[SYNC_STAGES-2:0], 1'b1};
            armed    <= armed | (flush_sr[SYNC_STAGES-1] & ncs_s);
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;
    assign ncs_fall  = armed & ~ncs_s & ncs_prev;

    assign rx_next  = {rx_sh[FRAME-2:0], copi_s};
    assign addr_now = rx_next[ADDR_W-1:0];
    assign rw_now   = rx_next[ADDR_W];

    assign c_rw   = rx_sh[FRAME-1];
    assign c_addr = rx_sh[DATA_W +: ADDR_W];
    assign c_data = rx_sh[DATA_W-1:0];

    // Address decode for the read snapshot and the write commit. An
    // out-of-range address matches nothing, so the snapshot stays zero.
    always_comb begin
        snap  = '0;
        c_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_now == ADDR_W'(i)) snap = reg_q[i];
            if (c_addr == ADDR_W'(i))   c_hit[i] = 1'b1;
        end
    end

    // Frame FSM, receive shift register, bit counter and read-data shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            rd_active <= 1'b0;
            tx_sh     <= '0;
            cipo_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cipo_q <= 1'b0;
                    if (ncs_rise) begin
                        state <= ST_COMMIT;
                    end else if (ncs_fall) begin
                        state     <= ST_ADDR;
                        bit_cnt   <= '0;
                        rx_sh     <= '0;
                        rd_active <= 1'b0;
                        tx_sh     <= '0;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (ncs_rise) begin
                        state  <= ST_COMMIT;
                        cipo_q <= 1'b0;
                    end else begin
                        if (sclk_rise && !ncs_s) begin
                            rx_sh <= rx_next;
                            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
                            if (state == ST_ADDR && bit_cnt == CNT_ALAST) begin
                                state     <= ST_DATA;
                                rd_active <= ~rw_now;
                                tx_sh     <= rw_now ? '0 : snap;
                            end
                        end
                        if (sclk_fall && state == ST_DATA && rd_active) begin
                            cipo_q <= tx_sh[DATA_W-1];
                            tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bit_cnt   <= '0;
                    rd_active <= 1'b0;
                    cipo_q    <= 1'b0;
                end
            endcase
        end
    end

    // Commit: only an exact-length frame may write; any other non-empty frame
    // is reported as an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= '0;
            frame_err <= 1'b0;
            if (state == ST_COMMIT) begin
                if (bit_cnt == CNT_FRAME) begin
                    if (c_rw) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (c_hit[i]) begin
                                reg_q[i]     <= c_data;
                                wr_strobe[i] <= 1'b1;
                            end
                        end
                    end
                end else if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs[g*DATA_W +: DATA_W] = reg_q[g];
    end

    assign cipo    = cipo_q;
    assign cipo_oe = ~ncs_s;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank. Instance a uses the default parameters.
// Instance b uses 8 x 16-bit registers with 4-bit addresses. The two
// instances share sclk/copi but each has its own ncs.
module tb_spi_reg_bank;

    logic         clk;
    logic         rst;
    logic         sclk;
    logic         copi;
    logic         ncs_a, ncs_b;
    logic         cipo_a, cipo_b;
    logic         cipo_oe_a, cipo_oe_b;
    logic [39:0]  regs_a;
    logic [127:0] regs_b;
    logic [4:0]   wr_strobe_a;
    logic [7:0]   wr_strobe_b;
    logic         frame_err_a, frame_err_b;

    int n_cmp = 0;
    int n_err = 0;
    int strb_a = 0, strb_b = 0, err_a = 0, err_b = 0;
    bit ff_seen = 0;
    logic oe_seen;

    spi_reg_bank u_a (
        .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs_a), .copi(copi),
        .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs(regs_a),
        .wr_strobe(wr_strobe_a), .frame_err(frame_err_a)
    );

    spi_reg_bank #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs_b), .copi(copi),
        .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs(regs_b),
        .wr_strobe(wr_strobe_b), .frame_err(frame_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and the "0xFF never reached register 1" watch.
    always @(negedge clk) begin
        strb_a = strb_a + $countones(wr_strobe_a);
        strb_b = strb_b + $countones(wr_strobe_b);
        if (frame_err_a) err_a = err_a + 1;
        if (frame_err_b) err_b = err_b + 1;
        if (regs_a[15:8] == 8'hFF) ff_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI frame, MSB first. word holds the nbits bits right-aligned. hp is
    // the sclk half-period in clk cycles. Read data is captured at the end of
    // each high phase for the last dw bits.
    task automatic xfer(input bit sel, input int nbits, input logic [31:0] word,
                        input int hp, input int dw, input bit end_frame,
                        output logic [31:0] rx);
        rx = '0;
        if (sel) ncs_b = 1'b0; else ncs_a = 1'b0;
        tick(hp);
        for (int k = nbits - 1; k >= 0; k--) begin
            copi = word[k];
            tick(hp);
            sclk = 1'b1;
            tick(hp);
            if (k == nbits - 1) oe_seen = sel ? cipo_oe_b : cipo_oe_a;
            if (k < dw) rx = {rx[30:0], (sel ? cipo_b : cipo_a)};
            sclk = 1'b0;
        end
        copi = 1'b0;
        if (end_frame) begin
            tick(hp);
            if (sel) ncs_b = 1'b1; else ncs_a = 1'b1;
        end
    endtask

    logic [15:0] vals [8] = '{16'h1234, 16'hBEEF, 16'h0001, 16'h8000,
                              16'hFFFF, 16'h5A5A, 16'hC3C3, 16'h0F0F};

    initial begin
        logic [31:0]  rx;
        logic [127:0] exp_b;
        int s0, e0;

        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs_a = 1'b1; ncs_b = 1'b1;
        tick(4);
        check("rst regs_a", regs_a, 0);
        check("rst strobe_a", wr_strobe_a, 0);
        check("rst err_a", frame_err_a, 0);
        check("rst cipo_a", cipo_a, 0);
        check("rst oe_a", cipo_oe_a, 0);
        check("rst regs_b", regs_b, 0);
        rst = 1'b0;
        tick(10);

        // Write 0xA5 to register 2 with an exact commit latency of 4 edges.
        s0 = strb_a;
        xfer(0, 16, 32'h82A5, 4, 8, 1, rx);
        tick(3);
        check("t1 before commit", regs_a, 0);
        tick(1);
        check("t1 regs", regs_a, 40'h0000A50000);
        check("t1 strobe", wr_strobe_a, 5'b00100);
        tick(1);
        check("t1 strobe drop", wr_strobe_a, 0);
        check("t1 strobe count", strb_a - s0, 1);
        check("t1 oe during frame", oe_seen, 1);
        check("t1 oe after frame", cipo_oe_a, 0);

        // Write 0x3C to register 4 and read it back.
        xfer(0, 16, 32'h843C, 4, 8, 1, rx);
        tick(8);
        check("t2 regs", regs_a, 40'h3C00A50000);
        s0 = strb_a;
        xfer(0, 16, 32'h0400, 4, 8, 1, rx);
        tick(8);
        check("t2 read data", rx[7:0], 8'h3C);
        check("t2 regs after read", regs_a, 40'h3C00A50000);
        check("t2 read strobes", strb_a - s0, 0);

        // Out-of-range address 9: no effect, no error, reads as zero.
        s0 = strb_a; e0 = err_a;
        xfer(0, 16, 32'h8955, 4, 8, 1, rx);
        tick(8);
        check("t3 regs", regs_a, 40'h3C00A50000);
        check("t3 strobes", strb_a - s0, 0);
        xfer(0, 16, 32'h0900, 4, 8, 1, rx);
        tick(8);
        check("t3 read data", rx[7:0], 8'h00);
        check("t3 errors", err_a - e0, 0);

        // Short (15-bit) and long (17-bit) frames to register 0.
        e0 = err_a; s0 = strb_a;
        xfer(0, 15, 32'h403B, 4, 8, 1, rx);
        tick(8);
        check("t4 short err", err_a - e0, 1);
        check("t4 short regs", regs_a, 40'h3C00A50000);
        xfer(0, 17, 32'h100EE, 4, 8, 1, rx);
        tick(8);
        check("t4 long err", err_a - e0, 2);
        check("t4 long regs", regs_a, 40'h3C00A50000);
        check("t4 strobes", strb_a - s0, 0);

        // Reset after bit 10 of a write 0xFF to register 1, with ncs held low
        // through the reset release.
        xfer(0, 10, 32'h207, 4, 8, 0, rx);
        rst = 1'b1;
        tick(3);
        check("t5 in reset", regs_a, 0);
        rst = 1'b0;
        s0 = strb_a; e0 = err_a;
        tick(8);
        ncs_a = 1'b1;
        tick(10);
        check("t5 aborted strobes", strb_a - s0, 0);
        check("t5 aborted err", err_a - e0, 0);
        check("t5 aborted regs", regs_a, 0);
        xfer(0, 16, 32'h8111, 4, 8, 1, rx);
        tick(8);
        check("t5 regs", regs_a, 40'h0000001100);
        check("t5 strobes", strb_a - s0, 1);
        check("t5 no 0xFF", ff_seen, 0);

        // Wide instance: clk = 4 x sclk, back-to-back writes, then reads.
        s0 = strb_b;
        exp_b = '0;
        for (int i = 0; i < 8; i++) begin
            xfer(1, 21, (32'h1 << 20) | (32'(i) << 16) | 32'(vals[i]), 2, 16, 1, rx);
            tick(2);
            exp_b[i*16 +: 16] = vals[i];
        end
        tick(8);
        check("t6 write strobes", strb_b - s0, 8);
        check("t6 regs", regs_b, exp_b);
        for (int i = 0; i < 8; i++) begin
            xfer(1, 21, 32'(i) << 16, 2, 16, 1, rx);
            tick(2);
            check($sformatf("t6 read %0d", i), rx[15:0], vals[i]);
        end
        tick(8);
        check("t6 total strobes", strb_b - s0, 8);
        check("t6 errors", err_b, 0);
        check("t6 regs after reads", regs_b, exp_b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
